// File: rtl/mips_imem_pkg.sv
// Shared types for the instruction-fetch responder: error codes and response payload.
package mips_imem_pkg;

    localparam int INSTR_W = 32;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_PARITY   = 2'b11;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
        logic [1:0]         err;
    } rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO; head is registered storage, zeroed while empty.
module imem_rsp_fifo
    import mips_imem_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = rsp_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    T                 slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : slots[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: credit-gated request, 1-cycle memory read, buffered response.
// Optional IMEM_PARITY_EN adds a stored even-parity bit per word and the prog_par_flip port.
module imem_fetch_responder
    import mips_imem_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [31:0]       rsp_pc,
    output logic [1:0]        rsp_err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
`ifdef IMEM_PARITY_EN
    input  logic              prog_par_flip,
`endif
    input  logic [31:0]       prog_data
);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
`else
    localparam int MEM_W = INSTR_W;
`endif
    localparam int            CNT_W   = $clog2(FIFO_DEPTH+1);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

    logic [MEM_W-1:0] mem [2**ADDR_W];
    logic [MEM_W-1:0] wr_word, rd_word;
    logic [31:2]      word_off;
    logic [1:0]       req_err, rd_err;
    logic [31:0]      rd_pc;
    logic             inflight, accept, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occ;
    rsp_t             push_data, head;

    assign word_off = req_pc[31:2] - BASE_ADDR[31:2];

    always_comb begin
        req_err = ERR_OK;
        if (req_pc[1:0] != 2'b00)
            req_err = ERR_MISALIGN;
        else if (req_pc < BASE_ADDR || |word_off[31:ADDR_W+2])
            req_err = ERR_RANGE;
    end

    // A pop this cycle frees a slot in time for the new request, so back-to-back fetches stream.
    assign pop       = rsp_valid && rsp_ready;
    assign occ       = {1'b0, fifo_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign req_ready = !reset && (occ < DEPTH_L);
    assign accept    = req_valid && req_ready;

`ifdef IMEM_PARITY_EN
    assign wr_word = {^prog_data ^ prog_par_flip, prog_data};
`else
    assign wr_word = prog_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            rd_pc    <= '0;
            rd_err   <= ERR_OK;
        end else begin
            inflight <= accept;
            if (accept) begin
                rd_pc  <= req_pc;
                rd_err <= req_err;
            end
        end
    end

    // Read and write share one block so a same-word collision returns the old contents.
    always_ff @(posedge clk) begin
        if (prog_we && !reset) mem[prog_addr] <= wr_word;
        if (accept && req_err == ERR_OK) rd_word <= mem[word_off[ADDR_W+1:2]];
    end

    always_comb begin
        push_data.pc    = rd_pc;
        push_data.err   = rd_err;
        push_data.instr = '0;
        if (rd_err == ERR_OK) begin
`ifdef IMEM_PARITY_EN
            if (^rd_word) push_data.err   = ERR_PARITY;
            else          push_data.instr = rd_word[INSTR_W-1:0];
`else
            push_data.instr = rd_word;
`endif
        end
    end

    imem_rsp_fifo #(.DEPTH(FIFO_DEPTH), .T(rsp_t)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_instr = head.instr;
    assign rsp_pc    = head.pc;
    assign rsp_err   = head.err;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomized bench for imem_fetch_responder against an in-order queue model of the fetch rules.
module tb_imem_fetch_responder;
    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'h0000_0000;

    typedef struct { logic [31:0] pc; logic [31:0] instr; logic [1:0] err; } exp_t;

    logic        clk = 0, reset = 1;
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, prog_we = 0;
    logic [31:0] req_pc = 0, rsp_instr, rsp_pc, prog_data = 0;
    logic [1:0]  rsp_err;
    logic [AW-1:0] prog_addr = 0;
`ifdef IMEM_PARITY_EN
    logic        prog_par_flip = 0;
`endif

    imem_fetch_responder #(.ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_pc(rsp_pc),
        .rsp_err(rsp_err), .prog_we(prog_we), .prog_addr(prog_addr),
`ifdef IMEM_PARITY_EN
        .prog_par_flip(prog_par_flip),
`endif
        .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [31:0] mmem [1024];
    bit          mbad [1024];
    exp_t        exp_q[$];
    logic [31:0] pend[$];
    int          acc_cyc[$], pop_cyc[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(logic [31:0] pc);
        exp_t r;
        int   idx;
        r.pc = pc; r.instr = 0; r.err = 0;
        if (pc % 4 != 0) r.err = 1;
        else if (pc < BASE || (pc - BASE) / 4 >= 1024) r.err = 2;
        else begin
            idx = int'((pc - BASE) / 4);
            if (mbad[idx]) r.err = 3;
            else r.instr = mmem[idx];
        end
        return r;
    endfunction

    // One clock: drive from pend, sample mid-low-phase, score, advance to next negedge.
    task automatic cycle();
        bit   acc, pop;
        exp_t e;
        req_valid = (pend.size() > 0);
        req_pc    = req_valid ? pend[0] : $urandom;
        #1;
        acc = req_valid && req_ready;
        pop = rsp_valid && rsp_ready;
        if (pop) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("spurious_rsp", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_pc", rsp_pc, e.pc);
                chk("rsp_instr", rsp_instr, e.instr);
                chk("rsp_err", {30'b0, rsp_err}, {30'b0, e.err});
            end
        end
        if (acc) begin
            exp_q.push_back(model(req_pc));
            void'(pend.pop_front());
            acc_cyc.push_back(cyc);
        end
        if (prog_we && !reset) begin
            mmem[prog_addr] = prog_data;
`ifdef IMEM_PARITY_EN
            mbad[prog_addr] = prog_par_flip;
`else
            mbad[prog_addr] = 0;
`endif
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < 60) begin cycle(); n++; end
        if (pend.size() > 0 || exp_q.size() > 0) chk("drain_timeout", 1, 0);
    endtask

    task automatic load(int a, logic [31:0] d);
        prog_we = 1; prog_addr = AW'(a); prog_data = d;
        cycle();
        prog_we = 0;
    endtask

    initial begin
        logic [31:0] pc;
        int r;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_instr", rsp_instr, 0);
        chk("rst_rsp_pc", rsp_pc, 0);
        chk("rst_rsp_err", {30'b0, rsp_err}, 0);
        @(negedge clk);
        reset = 0;
        #1 chk("rel_req_ready", {31'b0, req_ready}, 1);
        @(negedge clk);

        load(0, 32'h2008_0005); load(1, 32'h2009_0003);
        load(2, 32'h0109_5020); load(3, 32'h0800_0000);
        for (int i = 4; i < 16; i++) load(i, $urandom);

        // Back-to-back streaming and latency.
        acc_cyc.delete(); pop_cyc.delete();
        pend = '{32'd0, 32'd4, 32'd8, 32'd12};
        drain();
        chk("stream_accepts", acc_cyc.size(), 4);
        chk("stream_pops", pop_cyc.size(), 4);
        if (acc_cyc.size() == 4 && pop_cyc.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("stream_acc_cyc", acc_cyc[i], acc_cyc[0] + i);
                chk("stream_pop_cyc", pop_cyc[i], acc_cyc[0] + 2 + i);
            end

        // Backpressure: only two credits while consumer stalls.
        acc_cyc.delete();
        rsp_ready = 0;
        pend = '{32'd0, 32'd4, 32'd8, 32'd12};
        repeat (5) cycle();
        chk("bp_accepts", acc_cyc.size(), 2);
        #1 chk("bp_req_ready", {31'b0, req_ready}, 0);
        drain();

        // Error codes interleaved with good fetches.
        pend = '{32'd4, 32'h6, 32'd4, 32'h1000, 32'd4, 32'hFFFF_FFFC};
        drain();

        // Same-cycle program write and fetch of word 1.
        pend = '{32'd4};
        acc_cyc.delete();
        prog_we = 1; prog_addr = 1; prog_data = 32'hDEAD_BEEF;
        cycle();
        prog_we = 0;
        chk("rbw_accepted", acc_cyc.size(), 1);
        chk("rbw_model_old", exp_q.size() > 0 ? exp_q[0].instr : 0, 32'h2009_0003);
        drain();
        pend = '{32'd4};
        drain();

`ifdef IMEM_PARITY_EN
        prog_par_flip = 1; load(2, 32'h0109_5020); prog_par_flip = 0;
        pend = '{32'd8, 32'd4};
        drain();
        load(2, 32'h0109_5020);
`endif

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (pend.size() == 0 && $urandom_range(0, 3) != 0) begin
                r = $urandom_range(0, 9);
                if (r == 0)      pc = {26'($urandom_range(0, 15)), 6'($urandom_range(1, 3))};
                else if (r == 1) pc = ($urandom_range(0, 1) == 0) ? 32'h1000 + 4 * $urandom_range(0, 255) : 32'hFFFF_FFFC;
                else             pc = 4 * $urandom_range(0, 15);
                pend.push_back(pc);
            end
            if ($urandom_range(0, 7) == 0) begin
                prog_we = 1; prog_addr = AW'($urandom_range(0, 15)); prog_data = $urandom;
`ifdef IMEM_PARITY_EN
                prog_par_flip = ($urandom_range(0, 3) == 0);
`endif
            end
            cycle();
            prog_we = 0;
        end
        drain();

        // Asynchronous reset with two responses buffered.
        rsp_ready = 0;
        pend = '{32'd0, 32'd4};
        repeat (4) cycle();
        #2 reset = 1;
        #1;
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 0);
        exp_q.delete(); pend.delete();
        prog_we = 1; prog_addr = 0; prog_data = 32'h1234_5678;
        @(negedge clk); @(negedge clk);
        prog_we = 0;
        reset = 0;
        rsp_ready = 1;
        #1 chk("post_rst_req_ready", {31'b0, req_ready}, 1);
        repeat (5) begin
            cycle();
            chk("post_rst_no_rsp", {31'b0, rsp_valid}, 0);
        end
        pend = '{32'd0};
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
